// File: rtl/s1_serial_tx_if.sv
// s1_serial_tx_if -- bus bundle between the S1 serial transmitter and its
// surroundings: the RB1 register-bank read port and the serial frame link.
//
// Signals:
//   RB1_RW   RB1 read/write select, 1 = read
//   RB1_A    RB1 word address (3 bits)
//   RB1_Q    RB1 read data (18 bits), valid one cycle after RB1_A
//   sen      frame enable, active low
//   sd       serial data, MSB first while sen is low
//   S1_done  all frames sent
//
// Modports:
//   master   the transmitter (drives address, serial link and done)
//   slave    the environment (register bank and serial receiver)
interface s1_serial_tx_if;
    logic        RB1_RW;
    logic [2:0]  RB1_A;
    logic [17:0] RB1_Q;
    logic        sen;
    logic        sd;
    logic        S1_done;

    modport master (
        output RB1_RW,
        output RB1_A,
        input  RB1_Q,
        output sen,
        output sd,
        output S1_done
    );

    modport slave (
        input  RB1_RW,
        input  RB1_A,
        output RB1_Q,
        input  sen,
        input  sd,
        input  S1_done
    );
endinterface

// File: rtl/s1_serial_tx.sv
// s1_serial_tx -- reads FRAME_NUM words from register bank RB1 and sends each
// one as a serial frame {address[2:0], data[17:0]}, MSB first, on sd while
// the active-low enable sen is held low. S1_done rises on the edge that ends
// the last frame and holds until reset.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   s1_serial_tx_if.master: RB1_RW, RB1_A, RB1_Q, sen, sd, S1_done
//
// Parameters:
//   FRAME_NUM   number of frames sent, addresses 0..FRAME_NUM-1 (1..8)
//   GAP_CYCLES  extra sen-high idle cycles between frames (0..15)
//
// Optional feature (macro S1_PARITY_EN):
//   when defined, every frame carries a 22nd bit after data bit 0 holding
//   the even parity (XOR) of the 21 frame bits.
module s1_serial_tx #(
    parameter int FRAME_NUM  = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    s1_serial_tx_if.master  bus
);

`ifdef S1_PARITY_EN
    localparam int FRAME_BITS = 22;
`else
    localparam int FRAME_BITS = 21;
`endif
    // The frame MSB (idx[2]) goes straight to sd on leaving LOAD, so the
    // shift register only needs to hold the remaining bits.
    localparam int SHIFT_W = FRAME_BITS - 1;

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_NUM - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_READ  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t               state_r;
    logic [2:0]           idx_r;
    logic [SHIFT_W-1:0]   shift_r;
    logic [4:0]           bit_cnt_r;
    logic [3:0]           gap_cnt_r;
    logic                 rw_r;
    logic [2:0]           rb1_a_r;
    logic                 sen_r;
    logic                 sd_r;
    logic                 done_r;

`ifdef S1_PARITY_EN
    // Even parity over the 21 address+data bits of one frame.
    function automatic logic even_parity(input logic [20:0] frame);
        return ^frame;
    endfunction
`endif

    // Frame sequencer: reads one RB1 word per frame and serialises it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_READ;
            idx_r     <= 3'd0;
            shift_r   <= '0;
            bit_cnt_r <= 5'd0;
            gap_cnt_r <= 4'd0;
            rw_r      <= 1'b1;
            rb1_a_r   <= 3'd0;
            sen_r     <= 1'b1;
            sd_r      <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            rw_r <= 1'b1;
            case (state_r)
                ST_READ: begin
                    rb1_a_r <= idx_r;
                    sen_r   <= 1'b1;
                    sd_r    <= 1'b0;
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    // RB1_Q is valid only in this cycle; capture it whole.
`ifdef S1_PARITY_EN
                    shift_r <= {idx_r[1:0], bus.RB1_Q,
                                even_parity({idx_r, bus.RB1_Q})};
`else
                    shift_r <= {idx_r[1:0], bus.RB1_Q};
`endif
                    sen_r     <= 1'b0;
                    sd_r      <= idx_r[2];
                    bit_cnt_r <= 5'd0;
                    state_r   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        sen_r <= 1'b1;
                        sd_r  <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            // Address advances now so it is stable through
                            // GAP and READ.
                            idx_r     <= idx_r + 3'd1;
                            rb1_a_r   <= idx_r + 3'd1;
                            gap_cnt_r <= 4'd0;
                            if (GAP_CYCLES == 0) begin
                                state_r <= ST_READ;
                            end else begin
                                state_r <= ST_GAP;
                            end
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        sd_r      <= shift_r[SHIFT_W-1];
                        shift_r   <= {shift_r[SHIFT_W-2:0], 1'b0};
                    end
                end
                ST_GAP: begin
                    sen_r <= 1'b1;
                    sd_r  <= 1'b0;
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= ST_READ;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    sen_r  <= 1'b1;
                    sd_r   <= 1'b0;
                    done_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_READ;
                    sen_r   <= 1'b1;
                    sd_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RB1_RW  = rw_r;
    assign bus.RB1_A   = rb1_a_r;
    assign bus.sen     = sen_r;
    assign bus.sd      = sd_r;
    assign bus.S1_done = done_r;

endmodule

// File: tb/tb_s1_serial_tx.sv
// tb_s1_serial_tx -- self-checking bench for s1_serial_tx.
// A synchronous-read RB1 model feeds the transmitter; RB1_Q carries random
// garbage in every cycle except the one where the read data must be valid.
// Expected sen/sd/S1_done/RB1_A are computed each cycle from the frame
// timeline (frame i starts at edge 2 + i*period). An independent deserialiser
// rebuilds the words from sen/sd into an RB2 image compared against RB1.
module tb_s1_serial_tx;

    localparam int N = 8;
    localparam int G = 1;
`ifdef S1_PARITY_EN
    localparam int FL = 22;
`else
    localparam int FL = 21;
`endif
    localparam int P = FL + G + 2;
    localparam int DONE_EDGE = 2 + (N - 1) * P + FL;

    logic clk;
    logic rst;

    s1_serial_tx_if bus_if ();

    s1_serial_tx #(
        .FRAME_NUM  (N),
        .GAP_CYCLES (G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] mem [0:7];
    logic [17:0] rb2 [0:7];
    int          ev;
    int          n_checks;
    int          n_pass;
    logic        rx_prev;
    int          rx_cnt;
    logic [21:0] rx_sh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ev);
    endtask

    // Frame i as sent on the wire, right-aligned in FL bits.
    function automatic logic [21:0] frame_of(input int i);
        logic [21:0] f;
        logic [2:0]  a;
        a = 3'(i);
        f = '0;
        f[20:0] = {a, mem[i]};
`ifdef S1_PARITY_EN
        f = {f[20:0], ^f[20:0]};
`endif
        return f;
    endfunction

    // Expected outputs right after edge e (edge 1 = first edge out of reset).
    function automatic void model(input int e, output logic x_sen, output logic x_sd,
                                  output logic x_done, output int x_load, output int x_read);
        int          i;
        int          off;
        logic [21:0] f;
        x_sen  = 1'b1;
        x_sd   = 1'b0;
        x_done = (e >= DONE_EDGE);
        x_load = -1;
        x_read = -1;
        if (e >= 2) begin
            i   = (e - 2) / P;
            off = (e - 2) % P;
            if (i < N && off < FL) begin
                f     = frame_of(i);
                x_sen = 1'b0;
                x_sd  = f[FL - 1 - off];
            end
        end
        if ((e - 1) % P == 0 && (e - 1) / P < N) x_load = (e - 1) / P;
        if (e % P == 0 && e / P < N) x_read = e / P;
    endfunction

    // Deserialiser: one call per cycle with the sampled link.
    task automatic rx_sample(input logic s, input logic d);
        if (!s) begin
            if (rx_prev) rx_cnt = 0;
            rx_sh = {rx_sh[20:0], d};
            rx_cnt++;
        end else if (!rx_prev) begin
            check("rx_frame_len", 32'(rx_cnt), 32'(FL));
`ifdef S1_PARITY_EN
            check("rx_parity", 32'(rx_sh[0]), 32'(^rx_sh[21:1]));
            rb2[rx_sh[21:19]] = rx_sh[18:1];
`else
            rb2[rx_sh[20:18]] = rx_sh[17:0];
`endif
        end
        rx_prev = s;
    endtask

    task automatic step();
        logic x_sen;
        logic x_sd;
        logic x_done;
        int   x_load;
        int   x_read;
        @(posedge clk);
        ev++;
        #1;
        model(ev, x_sen, x_sd, x_done, x_load, x_read);
        check("sen", 32'(bus_if.sen), 32'(x_sen));
        check("sd", 32'(bus_if.sd), 32'(x_sd));
        check("S1_done", 32'(bus_if.S1_done), 32'(x_done));
        check("RB1_RW", 32'(bus_if.RB1_RW), 32'd1);
        if (x_load >= 0) check("RB1_A_load", 32'(bus_if.RB1_A), 32'(x_load));
        if (x_read >= 1) check("RB1_A_read", 32'(bus_if.RB1_A), 32'(x_read));
        if (x_done) check("RB1_A_done", 32'(bus_if.RB1_A), 32'(N - 1));
        // Synchronous read: data of the sampled address valid in the next cycle.
        if (x_load >= 0) bus_if.RB1_Q = mem[bus_if.RB1_A];
        else             bus_if.RB1_Q = 18'($urandom);
        rx_sample(bus_if.sen, bus_if.sd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sen"}, 32'(bus_if.sen), 32'd1);
        check({tag, "_sd"}, 32'(bus_if.sd), 32'd0);
        check({tag, "_done"}, 32'(bus_if.S1_done), 32'd0);
        check({tag, "_A"}, 32'(bus_if.RB1_A), 32'd0);
        check({tag, "_RW"}, 32'(bus_if.RB1_RW), 32'd1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        ev = 0;
        rx_prev = 1'b1;
        rx_cnt = 0;
        for (int i = 0; i < 8; i++) rb2[i] = ~mem[i];
    endtask

    task automatic compare_rb2(input string tag);
        for (int i = 0; i < N; i++) check(tag, 32'(rb2[i]), 32'(mem[i]));
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        ev = 0;
        rst = 1'b1;
        rx_prev = 1'b1;
        rx_cnt = 0;
        rx_sh = '0;
        bus_if.RB1_Q = 18'($urandom);

        // Step 1: reset state.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Step 2: word[i] = 3_0000 | i, full run plus 100 cycles in DONE.
        for (int i = 0; i < 8; i++) mem[i] = 18'h3_0000 | 18'(i);
        release_reset();
        repeat (DONE_EDGE + 100) step();
        compare_rb2("rb2_incr");

        // Step 3: random words, 2AAAA at address 5, zero at address 0;
        // reset pulsed during bit 10 of frame 3.
        for (int i = 0; i < 8; i++) mem[i] = 18'($urandom);
        mem[5] = 18'h2_AAAA;
        mem[0] = 18'h0_0000;
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_reset_outputs("reset2");
        release_reset();
        repeat (2 + 3 * P + (FL - 1 - 10)) step();
        check("mid_frame_sen_low", 32'(bus_if.sen), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_frame_rst");

        // Step 4: restart from address 0 after the mid-frame reset.
        release_reset();
        repeat (DONE_EDGE + 20) step();
        compare_rb2("rb2_rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
